// File: rtl/riscv_single_cycle_core.sv
// rtl/riscv_single_cycle_core.sv - single-cycle RV32I core with unified word memory
module rv_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_instr,
    input  logic        Jump,
    input  logic [31:0] jump_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] PC,
    output logic [31:0] pc_plus4,
    output logic [31:0] instr
);
    logic [31:0] next_pc;

    assign instr    = mem_instr;
    assign pc_plus4 = PC + 32'd4;
    assign next_pc  = Jump ? jump_target : (branch_taken ? branch_target : pc_plus4);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) PC <= RESET_PC;
        else        PC <= next_pc;
    end
endmodule

module rv_decode (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic [31:0] wb_data,
    output logic        RegWrite,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        ALUSrc,
    output logic        Branch,
    output logic        MemtoReg,
    output logic        Jump,
    output logic        AUIPC,
    output logic        LUI,
    output logic        JALR,
    output logic [2:0]  funct3,
    output logic [3:0]  alu_ctl,
    output logic [31:0] imm,
    output logic [31:0] read_data1,
    output logic [31:0] read_data2
);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    logic [31:0] reg_file [0:31];
    logic [6:0]  opcode;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // alu_ctl = {sub/arith-shift select, funct3}; address calculations use plain add
    always_comb begin
        RegWrite = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        ALUSrc   = 1'b0;
        Branch   = 1'b0;
        MemtoReg = 1'b0;
        Jump     = 1'b0;
        AUIPC    = 1'b0;
        LUI      = 1'b0;
        JALR     = 1'b0;
        alu_ctl  = 4'b0000;
        imm      = imm_i;
        case (opcode)
            OP_R: begin
                RegWrite = 1'b1;
                alu_ctl  = {instr[30], funct3};
            end
            OP_IMM: begin
                RegWrite = 1'b1;
                ALUSrc   = 1'b1;
                alu_ctl  = {(funct3 == 3'b101) & instr[30], funct3};
            end
            OP_LOAD: begin
                RegWrite = 1'b1;
                MemRead  = 1'b1;
                MemtoReg = 1'b1;
                ALUSrc   = 1'b1;
            end
            OP_STORE: begin
                MemWrite = 1'b1;
                ALUSrc   = 1'b1;
                imm      = imm_s;
            end
            OP_BRANCH: begin
                Branch = 1'b1;
                imm    = imm_b;
            end
            OP_JAL: begin
                Jump     = 1'b1;
                RegWrite = 1'b1;
                imm      = imm_j;
            end
            OP_JALR: begin
                Jump     = 1'b1;
                JALR     = 1'b1;
                RegWrite = 1'b1;
                ALUSrc   = 1'b1;
            end
            OP_LUI: begin
                RegWrite = 1'b1;
                LUI      = 1'b1;
                ALUSrc   = 1'b1;
                imm      = imm_u;
            end
            OP_AUIPC: begin
                RegWrite = 1'b1;
                AUIPC    = 1'b1;
                ALUSrc   = 1'b1;
                imm      = imm_u;
            end
            default: ;
        endcase
    end

    assign read_data1 = (rs1 == 5'd0) ? 32'd0 : reg_file[rs1];
    assign read_data2 = (rs2 == 5'd0) ? 32'd0 : reg_file[rs2];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) reg_file[i] <= 32'd0;
        end else if (RegWrite && rd != 5'd0) begin
            reg_file[rd] <= wb_data;
        end
    end
endmodule

module rv_execute (
    input  logic [31:0] pc,
    input  logic [31:0] read_data1,
    input  logic [31:0] read_data2,
    input  logic [31:0] imm,
    input  logic [3:0]  alu_ctl,
    input  logic [2:0]  funct3,
    input  logic        ALUSrc,
    input  logic        AUIPC,
    input  logic        LUI,
    input  logic        Branch,
    input  logic        JALR,
    output logic [31:0] ALU_result,
    output logic        branch_taken,
    output logic [31:0] branch_target,
    output logic [31:0] jump_target
);
    logic [31:0] op_a, op_b;
    logic [4:0]  shamt;
    logic        cond;

    assign op_a  = AUIPC ? pc : (LUI ? 32'd0 : read_data1);
    assign op_b  = ALUSrc ? imm : read_data2;
    assign shamt = op_b[4:0];

    always_comb begin
        ALU_result = op_a + op_b;
        casez (alu_ctl)
            4'b1000: ALU_result = op_a - op_b;
            4'b?001: ALU_result = op_a << shamt;
            4'b?010: ALU_result = {31'd0, $signed(op_a) < $signed(op_b)};
            4'b?011: ALU_result = {31'd0, op_a < op_b};
            4'b?100: ALU_result = op_a ^ op_b;
            4'b0101: ALU_result = op_a >> shamt;
            4'b1101: ALU_result = $unsigned($signed(op_a) >>> shamt);
            4'b?110: ALU_result = op_a | op_b;
            4'b?111: ALU_result = op_a & op_b;
            default: ;
        endcase
    end

    always_comb begin
        cond = 1'b0;
        case (funct3)
            3'b000:  cond = (read_data1 == read_data2);
            3'b001:  cond = (read_data1 != read_data2);
            3'b100:  cond = ($signed(read_data1) <  $signed(read_data2));
            3'b101:  cond = ($signed(read_data1) >= $signed(read_data2));
            3'b110:  cond = (read_data1 <  read_data2);
            3'b111:  cond = (read_data1 >= read_data2);
            default: cond = 1'b0;
        endcase
    end

    assign branch_taken  = Branch & cond;
    assign branch_target = pc + imm;
    assign jump_target   = JALR ? {ALU_result[31:1], 1'b0} : branch_target;
endmodule

module rv_mem #(
    parameter int MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] instr,
    output logic [31:0] rdata
);
    localparam int AW = $clog2(MEM_WORDS);

    logic [31:0]   mem [0:MEM_WORDS-1];
    logic [AW-1:0] i_idx, d_idx;
    logic          unused_addr_bits;

    // word index drops the byte offset and wraps by truncation
    assign i_idx = pc[AW+1:2];
    assign d_idx = addr[AW+1:2];
    assign unused_addr_bits = ^{pc[31:AW+2], pc[1:0], addr[31:AW+2], addr[1:0]};

    assign instr = mem[i_idx];
    assign rdata = MemRead ? mem[d_idx] : 32'd0;

    // contents are deliberately not reset so a preloaded program survives
    always_ff @(posedge clk) begin
        if (reset && MemWrite) mem[d_idx] <= wdata;
    end
endmodule

module riscv_single_cycle_core #(
    parameter int          MEM_WORDS = 1024,
    parameter logic [31:0] RESET_PC  = 32'h0
) (
    input logic clk,
    input logic reset
);
    logic [31:0] pc, pc_plus4, instr, mem_instr, imm;
    logic [31:0] rs1_data, rs2_data, alu_result, rdata, wb_data;
    logic [31:0] branch_target, jump_target;
    logic        reg_write, mem_read, mem_write, alu_src, branch, mem_to_reg;
    logic        jump, auipc, lui, jalr, branch_taken;
    logic [2:0]  funct3;
    logic [3:0]  alu_ctl;

    rv_fetch #(.RESET_PC(RESET_PC)) fetch (
        .clk(clk), .reset(reset), .mem_instr(mem_instr), .Jump(jump),
        .jump_target(jump_target), .branch_taken(branch_taken),
        .branch_target(branch_target), .PC(pc), .pc_plus4(pc_plus4), .instr(instr)
    );

    rv_decode decode (
        .clk(clk), .reset(reset), .instr(instr), .wb_data(wb_data),
        .RegWrite(reg_write), .MemRead(mem_read), .MemWrite(mem_write),
        .ALUSrc(alu_src), .Branch(branch), .MemtoReg(mem_to_reg), .Jump(jump),
        .AUIPC(auipc), .LUI(lui), .JALR(jalr), .funct3(funct3), .alu_ctl(alu_ctl),
        .imm(imm), .read_data1(rs1_data), .read_data2(rs2_data)
    );

    rv_execute execute (
        .pc(pc), .read_data1(rs1_data), .read_data2(rs2_data), .imm(imm),
        .alu_ctl(alu_ctl), .funct3(funct3), .ALUSrc(alu_src), .AUIPC(auipc),
        .LUI(lui), .Branch(branch), .JALR(jalr), .ALU_result(alu_result),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump_target(jump_target)
    );

    rv_mem #(.MEM_WORDS(MEM_WORDS)) mem (
        .clk(clk), .reset(reset), .pc(pc), .addr(alu_result), .wdata(rs2_data),
        .MemRead(mem_read), .MemWrite(mem_write), .instr(mem_instr), .rdata(rdata)
    );

    assign wb_data = mem_to_reg ? rdata : (jump ? pc_plus4 : alu_result);
endmodule

// File: tb/tb_riscv_single_cycle_core.sv
// tb/tb_riscv_single_cycle_core.sv - scoreboard bench for riscv_single_cycle_core
module tb_riscv_single_cycle_core;
    localparam int K_PC  = 0;
    localparam int K_REG = 1;
    localparam int K_MEM = 2;
    localparam int K_MW  = 3;

    typedef struct {
        int          cyc;
        int          kind;
        int          idx;
        logic [31:0] exp;
        string       tag;
    } exp_t;

    logic clk;
    logic reset;
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    riscv_single_cycle_core #(.MEM_WORDS(1024), .RESET_PC(32'h0)) dut (
        .clk(clk),
        .reset(reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic push(input int cyc, input int kind, input int idx,
                        input logic [31:0] exp, input string tag);
        exp_t e;
        e.cyc = cyc; e.kind = kind; e.idx = idx; e.exp = exp; e.tag = tag;
        sb.push_back(e);
    endtask

    function automatic logic [31:0] observe(input int kind, input int idx);
        case (kind)
            K_PC:    return dut.fetch.PC;
            K_REG:   return dut.decode.reg_file[idx];
            K_MEM:   return dut.mem.mem[idx];
            default: return {31'd0, dut.mem.MemWrite};
        endcase
    endfunction

    task automatic drain(input int cyc);
        int i;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].cyc == cyc) begin
                check($sformatf("c%0d_%s", cyc, sb[i].tag), observe(sb[i].kind, sb[i].idx), sb[i].exp);
                sb.delete(i);
            end else begin
                i++;
            end
        end
    endtask

    task automatic step(input int cyc);
        @(posedge clk);
        @(negedge clk);
        drain(cyc);
    endtask

    logic [31:0] prog [0:22];
    logic [31:0] pc_exp [1:25];

    initial begin
        reset = 1'b0;
        prog = '{32'h00500093, 32'h00300113, 32'h002081B3, 32'h40110333,
                 32'h04302023, 32'h04002203, 32'h00418463, 32'h00100293,
                 32'h00419463, 32'h02051063, 32'h12345437, 32'h00700013,
                 32'h00001497, 32'h02100093, 32'h00100513, 32'h000083E7,
                 32'h00000000, 32'h40135593, 32'h00132633, 32'h001336B3,
                 32'h01C35713, 32'hFFF1C793, 32'h0000006F};
        for (int i = 0; i < 1024; i++) dut.mem.mem[i] = 32'h0;
        for (int i = 0; i < 23; i++) dut.mem.mem[i] = prog[i];

        // expected results are queued up front, each tagged with its completion cycle
        push(0, K_PC, 0, 32'h0, "reset_pc");
        for (int r = 1; r < 32; r++) push(0, K_REG, r, 32'h0, $sformatf("reset_x%0d", r));
        push(0, K_MW, 0, 32'h0, "reset_memwrite");

        pc_exp = '{32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h20, 32'h24,
                   32'h28, 32'h2C, 32'h30, 32'h34, 32'h38, 32'h3C, 32'h20, 32'h24,
                   32'h44, 32'h48, 32'h4C, 32'h50, 32'h54, 32'h58, 32'h58, 32'h58, 32'h58};
        for (int c = 1; c <= 25; c++) push(c, K_PC, 0, pc_exp[c], "pc");

        push(1,  K_REG, 1,  32'h5,        "addi_x1");
        push(2,  K_REG, 2,  32'h3,        "addi_x2");
        push(3,  K_REG, 3,  32'h8,        "add_x3");
        push(3,  K_MW,  0,  32'h0,        "memwrite_pre");
        push(4,  K_REG, 6,  32'hFFFFFFFE, "sub_x6");
        push(4,  K_MW,  0,  32'h1,        "memwrite_sw");
        push(5,  K_MEM, 16, 32'h8,        "sw_mem16");
        push(5,  K_MW,  0,  32'h0,        "memwrite_post");
        push(6,  K_REG, 4,  32'h8,        "lw_x4");
        push(8,  K_REG, 5,  32'h0,        "beq_skip_x5");
        push(10, K_REG, 8,  32'h12345000, "lui_x8");
        push(11, K_REG, 0,  32'h0,        "x0_discard");
        push(12, K_REG, 9,  32'h00001030, "auipc_x9");
        push(13, K_REG, 1,  32'h21,       "addi_x1_21");
        push(15, K_REG, 7,  32'h40,       "jalr_link_x7");
        push(18, K_REG, 11, 32'hFFFFFFFF, "srai_x11");
        push(19, K_REG, 12, 32'h1,        "slt_x12");
        push(20, K_REG, 13, 32'h0,        "sltu_x13");
        push(21, K_REG, 14, 32'h0000000F, "srli_x14");
        push(22, K_REG, 15, 32'hFFFFFFF7, "xori_x15");
        push(26, K_PC,  0,  32'h0,        "rereset_pc");
        push(26, K_REG, 1,  32'h0,        "rereset_x1");
        push(26, K_REG, 7,  32'h0,        "rereset_x7");
        push(26, K_MEM, 16, 32'h8,        "rereset_mem16_kept");
        push(26, K_MEM, 0,  32'h00500093, "rereset_prog_kept");
        push(27, K_PC,  0,  32'h4,        "restart_pc");
        push(27, K_REG, 1,  32'h5,        "restart_x1");

        @(negedge clk);
        @(negedge clk);
        drain(0);
        reset = 1'b1;
        for (int c = 1; c <= 25; c++) step(c);

        reset = 1'b0;
        @(posedge clk);
        step(26);
        reset = 1'b1;
        step(27);

        check("scoreboard_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
